// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the trainable perceptron classifier.
package perceptron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Accumulator width wide enough that N_IN weights plus the bias never overflow.
    function automatic int unsigned acc_width(input int unsigned n_in, input int unsigned w_w);
        return w_w + int'($clog2(n_in + 1));
    endfunction

    // Signed w_w-bit value stepped by +1 or -1, clamped to the representable range.
    function automatic int sat_add(input int value, input logic up, input int w_w);
        int lo;
        int hi;
        int r;
        lo = -(2 ** (w_w - 1));
        hi = (2 ** (w_w - 1)) - 1;
        r  = up ? (value + 1) : (value - 1);
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/perceptron_weight_bank.sv
// Weight and bias storage: write port, indexed weight read, parallel saturating update.
module perceptron_weight_bank
    import perceptron_pkg::*;
#(
    parameter int unsigned N_IN   = 8,
    parameter int unsigned W_W    = 8,
    parameter int          W_INIT = 0,
    localparam int unsigned ADDR_W = $clog2(N_IN + 1),
    localparam int unsigned IDX_W  = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [W_W-1:0]    wr_data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic signed [W_W-1:0]    rd_data_c,
    output logic signed [W_W-1:0]    bias_c,
    input  logic                     upd_en,
    input  logic [N_IN-1:0]          upd_mask,
    input  logic                     upd_up
);

    // Entries 0..N_IN-1 are the weights, entry N_IN is the bias.
    logic signed [W_W-1:0] w [N_IN+1];
    logic [N_IN:0]         upd_sel_c;

    assign upd_sel_c = {1'b1, upd_mask};

    // Register update: reset, then host write, then learning step (never concurrent with a write).
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_IN) + 1; i++) begin
            if (!rst_n) begin
                w[i] <= W_W'(W_INIT);
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                w[i] <= wr_data;
            end else if (upd_en && upd_sel_c[i]) begin
                w[i] <= W_W'(sat_add(int'(w[i]), upd_up, int'(W_W)));
            end
        end
    end

    // Weight selected by the accumulation index.
    always_comb begin
        rd_data_c = w[0];
        for (int i = 1; i < int'(N_IN); i++) begin
            if (rd_idx == IDX_W'(i)) rd_data_c = w[i];
        end
    end

    assign bias_c = w[N_IN];

endmodule

// File: rtl/perceptron_learn.sv
// Start/done perceptron core: serial MAC over binary inputs, threshold decision, optional learning step.
module perceptron_learn
    import perceptron_pkg::*;
#(
    parameter int unsigned N_IN   = 8,
    parameter int unsigned W_W    = 8,
    parameter int          W_INIT = 0,
    localparam int unsigned ADDR_W = $clog2(N_IN + 1),
    localparam int unsigned ACC_W  = acc_width(N_IN, W_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          x_in,
    input  logic                     start,
    input  logic                     train,
    input  logic                     target,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [W_W-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     classification,
    output logic signed [ACC_W-1:0]  sum_out
);

    localparam int unsigned IDX_W = $clog2(N_IN);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic [N_IN-1:0]         x_q;
    logic                    train_q;
    logic                    target_q;

    logic signed [W_W-1:0]   rd_data_c;
    logic signed [W_W-1:0]   bias_c;
    logic signed [ACC_W-1:0] sum_c;
    logic                    decision_c;
    logic                    wr_en_c;
    logic                    upd_en_c;

    // Host writes only land while idle; the learning step fires in UPDATE.
    assign wr_en_c    = wr_en && (state == ST_IDLE);
    assign upd_en_c   = (state == ST_UPDATE);
    assign sum_c      = acc + ACC_W'(bias_c);
    assign decision_c = ~sum_c[ACC_W-1];

    perceptron_weight_bank #(
        .N_IN   (N_IN),
        .W_W    (W_W),
        .W_INIT (W_INIT)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en_c),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_idx    (idx),
        .rd_data_c (rd_data_c),
        .bias_c    (bias_c),
        .upd_en    (upd_en_c),
        .upd_mask  (x_q),
        .upd_up    (target_q)
    );

    // Transaction FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            acc            <= '0;
            x_q            <= '0;
            train_q        <= 1'b0;
            target_q       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            classification <= 1'b0;
            sum_out        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_q      <= x_in;
                        train_q  <= train;
                        target_q <= target;
                        acc      <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (x_q[idx]) acc <= acc + ACC_W'(rd_data_c);
                    if (idx == IDX_W'(N_IN - 1)) begin
                        idx   <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DECIDE: begin
                    classification <= decision_c;
                    sum_out        <= sum_c;
                    if (train_q && (decision_c != target_q)) begin
                        state <= ST_UPDATE;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_learn.sv
// Scoreboard bench for perceptron_learn against an integer reference model.
module tb_perceptron_learn;

    localparam int N_IN   = 8;
    localparam int W_W    = 8;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 12;
    localparam int W_MAX  = 127;
    localparam int W_MIN  = -128;

    logic                    clk     = 1'b0;
    logic                    rst_n   = 1'b0;
    logic                    start   = 1'b0;
    logic                    train   = 1'b0;
    logic                    target  = 1'b0;
    logic                    wr_en   = 1'b0;
    logic [N_IN-1:0]         x_in    = '0;
    logic [ADDR_W-1:0]       wr_addr = '0;
    logic signed [W_W-1:0]   wr_data = '0;
    logic                    busy;
    logic                    done;
    logic                    classification;
    logic signed [ACC_W-1:0] sum_out;

    perceptron_learn #(
        .N_IN   (N_IN),
        .W_W    (W_W),
        .W_INIT (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .x_in           (x_in),
        .start          (start),
        .train          (train),
        .target         (target),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done),
        .classification (classification),
        .sum_out        (sum_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int sum;
        int cls;
        int done_cyc;
        int id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mw[N_IN+1];
    int   txn_id = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic int clamp(input int v);
        if (v > W_MAX) return W_MAX;
        if (v < W_MIN) return W_MIN;
        return v;
    endfunction

    function automatic void model_write(input int addr, input int data);
        if (addr <= N_IN) mw[addr] = data;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i <= N_IN; i++) mw[i] = 0;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge where done is seen.
    task automatic issue(input logic [N_IN-1:0] x, input bit tr, input bit tg,
                         input bit do_wr, input int addr, input int data, input int hammer);
        exp_t e;
        int   s;
        bit   cls;
        bit   upd;
        int   k;
        if (do_wr) model_write(addr, data);
        s = mw[N_IN];
        for (int i = 0; i < N_IN; i++) if (x[i]) s += mw[i];
        cls = (s >= 0);
        upd = tr && (cls != tg);
        if (upd) begin
            for (int i = 0; i < N_IN; i++) if (x[i]) mw[i] = clamp(mw[i] + (tg ? 1 : -1));
            mw[N_IN] = clamp(mw[N_IN] + (tg ? 1 : -1));
        end
        e.sum      = s;
        e.cls      = int'(cls);
        e.done_cyc = cyc + N_IN + 2 + (upd ? 1 : 0);
        e.id       = txn_id;
        txn_id++;
        sb.push_back(e);

        x_in    = x;
        train   = tr;
        target  = tg;
        start   = 1'b1;
        wr_en   = do_wr;
        wr_addr = ADDR_W'(addr);
        wr_data = W_W'(data);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int h = 0; h < hammer; h++) begin
            start   = 1'b1;
            x_in    = N_IN'($urandom);
            train   = 1'($urandom);
            target  = 1'($urandom);
            wr_en   = 1'b1;
            wr_addr = ADDR_W'($urandom);
            wr_data = W_W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", int'(done === 1'b1), 1);
        check("busy_at_done", int'(busy), 0);
    endtask

    task automatic wr(input int addr, input int data);
        model_write(addr, data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = W_W'(data);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Bias alone, then each weight plus bias, observed through plain inference.
    task automatic probe_all();
        issue('0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < N_IN; i++) begin
            logic [N_IN-1:0] m;
            m = '0;
            m[i] = 1'b1;
            issue(m, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done with no pending transaction (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("sum_out[%0d]", mon_e.id), int'(sum_out), mon_e.sum);
                check($sformatf("class[%0d]", mon_e.id), int'(classification), mon_e.cls);
                check($sformatf("done_cycle[%0d]", mon_e.id), cyc, mon_e.done_cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_class", int'(classification), 0);
        check("rst_sum", int'(sum_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero weights, all inputs set: sum 0 sits on the positive side.
        issue(8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Known weights, below and exactly at threshold.
        for (int i = 0; i < N_IN; i++) wr(i, i + 1);
        wr(N_IN, -10);
        issue(8'b0000_0101, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        wr(N_IN, -4);
        issue(8'b0000_0101, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        wr(12, 99);
        issue(8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Training from zero: one error step, then a correct repeat.
        for (int i = 0; i <= N_IN; i++) wr(i, 0);
        issue(8'h03, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        probe_all();
        issue(8'h03, 1'b1, 1'b0, 1'b0, 0, 0, 0);

        // Saturation at both ends.
        wr(0, 127);
        wr(N_IN, -128);
        issue(8'h01, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        probe_all();
        wr(0, -128);
        wr(1, 127);
        wr(N_IN, 127);
        issue(8'h03, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        probe_all();

        // Starts and writes while busy must be ignored.
        issue(8'hA5, 1'b1, 1'b1, 1'b0, 0, 0, 4);
        probe_all();

        // Randomised traffic, including a write in the same cycle as start.
        for (int t = 0; t < 40; t++) begin
            bit dw;
            dw = ($urandom_range(0, 2) == 0);
            issue(N_IN'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  dw, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128, 0);
        end

        // Reset in the middle of accumulation aborts without a done pulse.
        for (int i = 0; i <= N_IN; i++) wr(i, int'($urandom_range(1, 50)));
        x_in  = 8'hFF;
        train = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum_out), 0);
        check("abort_class", int'(classification), 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        probe_all();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
